// File: rtl/nibble_dispatch.sv
// nibble_dispatch: upstream feeder for the 1-to-2 nibble demultiplexer.
// Buffers incoming nibbles in a small FIFO, assigns each a destination
// channel (round-robin or taken from in_dest) and presents one registered
// nibble at a time on sel/data. The nibble is held until the chosen channel
// accepts it.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   clr                 synchronous clear of cnt0/cnt1/stall_err
//   in_valid/in_ready   input handshake; in_ready = !fifo_full
//   in_data, in_dest    input nibble and its channel (in_dest only when RR_MODE=0)
//   sel, data           registered demux select/data; data is 0 when idle
//   out_valid           sel/data hold a pending nibble
//   ch_ready[1:0]       per-channel accept, bit sel applies
//   cnt0, cnt1          per-channel delivery counters (wrapping)
//   stall_err           sticky: a stall lasted TIMEOUT cycles
module nibble_dispatch #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned RR_MODE    = 1,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dest,
  output logic              in_ready,
  output logic              sel,
  output logic [DATA_W-1:0] data,
  output logic              out_valid,
  input  logic [1:0]        ch_ready,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic              stall_err
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned StallW = $clog2(TIMEOUT + 1);
  localparam int unsigned EntryW = DATA_W + 1;

  localparam logic [PtrW:0]     FullCnt    = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [StallW-1:0] TimeoutCnt = StallW'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  // FIFO storage; entry = {dest, data}
  logic [EntryW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]     count_q, count_d;

  state_e              state_q, state_d;
  logic                sel_q, sel_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rr_q, rr_d;
  logic [CNT_W-1:0]    cnt0_q, cnt0_d;
  logic [CNT_W-1:0]    cnt1_q, cnt1_d;
  logic [StallW-1:0]   stall_q, stall_d;
  logic                err_q, err_d;

  logic              fifo_full, fifo_empty;
  logic              accept, xfer, slot_free, pop, bypass, push;
  logic              dest_in;
  logic [EntryW-1:0] entry_in, entry_head;

  assign fifo_full  = (count_q == FullCnt);
  assign fifo_empty = (count_q == '0);
  assign in_ready   = ~fifo_full;
  assign out_valid  = (state_q == StHold);
  assign sel        = sel_q;
  assign data       = data_q;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;
  assign stall_err  = err_q;

  assign dest_in    = (RR_MODE != 0) ? rr_q : in_dest;
  assign entry_in   = {dest_in, in_data};
  assign entry_head = mem_q[rd_ptr_q];

  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & ch_ready[sel_q];
  assign slot_free = ~out_valid | xfer;
  // FIFO head has priority over a same-cycle input to keep ordering
  assign pop       = slot_free & ~fifo_empty;
  assign bypass    = slot_free & fifo_empty & accept;
  assign push      = accept & ~bypass;

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // Output register FSM
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    case (state_q)
      StIdle, StHold: begin
        if (slot_free) begin
          if (pop) begin
            state_d = StHold;
            sel_d   = entry_head[EntryW-1];
            data_d  = entry_head[DATA_W-1:0];
          end else if (bypass) begin
            state_d = StHold;
            sel_d   = dest_in;
            data_d  = in_data;
          end else begin
            // sel keeps its last value while idle
            state_d = StIdle;
            data_d  = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        data_d  = '0;
      end
    endcase
  end

  assign rr_d = rr_q ^ accept;

  // Stall timeout and delivery counters; clr overrides a same-cycle transfer
  always_comb begin
    stall_d = stall_q;
    err_d   = err_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    if (out_valid && !xfer) begin
      if (stall_q != TimeoutCnt) stall_d = stall_q + 1'b1;
      if (stall_d == TimeoutCnt) err_d = 1'b1;
    end else begin
      stall_d = '0;
    end
    if (xfer) begin
      if (sel_q) cnt1_d = cnt1_q + 1'b1;
      else       cnt0_d = cnt0_q + 1'b1;
    end
    if (clr) begin
      stall_d = '0;
      err_d   = 1'b0;
      cnt0_d  = '0;
      cnt1_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StIdle;
      sel_q    <= 1'b0;
      data_q   <= '0;
      rr_q     <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
      stall_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      rr_q     <= rr_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_nibble_dispatch.sv
// Bench for nibble_dispatch: instance 0 in round-robin mode, instance 1 in
// directed mode, both driven by the same inputs. A queue-style model of
// pending nibbles predicts every output after each clock edge; directed
// steps add fixed expectations for the scenarios of interest.
module tb_nibble_dispatch;

  localparam int D = 4;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_dest = 1'b0;
  logic [1:0] ch_ready = '0;

  logic       in_ready_w [2];
  logic       sel_w [2];
  logic [3:0] data_w [2];
  logic       out_valid_w [2];
  logic [7:0] cnt0_w [2];
  logic [7:0] cnt1_w [2];
  logic       err_w [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_dispatch #(.DATA_W(4), .FIFO_DEPTH(D), .CNT_W(8), .RR_MODE(1), .TIMEOUT(T)) u_rr (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_dest(in_dest), .in_ready(in_ready_w[0]), .sel(sel_w[0]), .data(data_w[0]),
    .out_valid(out_valid_w[0]), .ch_ready(ch_ready), .cnt0(cnt0_w[0]), .cnt1(cnt1_w[0]),
    .stall_err(err_w[0])
  );

  nibble_dispatch #(.DATA_W(4), .FIFO_DEPTH(D), .CNT_W(8), .RR_MODE(0), .TIMEOUT(T)) u_dir (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_dest(in_dest), .in_ready(in_ready_w[1]), .sel(sel_w[1]), .data(data_w[1]),
    .out_valid(out_valid_w[1]), .ch_ready(ch_ready), .cnt0(cnt0_w[1]), .cnt1(cnt1_w[1]),
    .stall_err(err_w[1])
  );

  // Model: pending nibbles as a circular list, plus the presented slot
  logic [4:0] m_buf [2][D];
  int         m_hd [2];
  int         m_n [2];
  bit         m_v [2];
  bit         m_sel [2];
  int         m_data [2];
  bit         m_rr [2];
  int         m_cnt [2][2];
  int         m_stall [2];
  bit         m_err [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_hd[i] = 0; m_n[i] = 0; m_v[i] = 0; m_sel[i] = 0; m_data[i] = 0;
      m_rr[i] = 0; m_cnt[i][0] = 0; m_cnt[i][1] = 0; m_stall[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    bit         acc, xfer, old_v, old_sel, dest;
    logic [4:0] e;
    old_v   = m_v[i];
    old_sel = m_sel[i];
    acc     = in_valid && (m_n[i] < D);
    xfer    = m_v[i] && ch_ready[m_sel[i]];
    if (acc) begin
      dest = (i == 0) ? m_rr[i] : in_dest;
      m_buf[i][(m_hd[i] + m_n[i]) % D] = {dest, in_data};
      m_n[i]++;
      m_rr[i] = !m_rr[i];
    end
    if (!m_v[i] || xfer) begin
      if (m_n[i] > 0) begin
        e = m_buf[i][m_hd[i]];
        m_hd[i] = (m_hd[i] + 1) % D;
        m_n[i]--;
        m_v[i] = 1;
        m_sel[i] = e[4];
        m_data[i] = int'(e[3:0]);
      end else begin
        m_v[i] = 0;
        m_data[i] = 0;
      end
    end
    if (clr) begin
      m_cnt[i][0] = 0; m_cnt[i][1] = 0; m_stall[i] = 0; m_err[i] = 0;
    end else begin
      if (xfer) m_cnt[i][old_sel] = (m_cnt[i][old_sel] + 1) % 256;
      if (old_v && !xfer) begin
        if (m_stall[i] < T) m_stall[i]++;
        if (m_stall[i] >= T) m_err[i] = 1;
      end else begin
        m_stall[i] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input int i, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic check_all(input int i);
    chk("out_valid", i, int'(out_valid_w[i]), int'(m_v[i]));
    chk("sel", i, int'(sel_w[i]), int'(m_sel[i]));
    chk("data", i, int'(data_w[i]), m_data[i]);
    chk("in_ready", i, int'(in_ready_w[i]), int'(m_n[i] < D));
    chk("cnt0", i, int'(cnt0_w[i]), m_cnt[i][0]);
    chk("cnt1", i, int'(cnt1_w[i]), m_cnt[i][1]);
    chk("stall_err", i, int'(err_w[i]), int'(m_err[i]));
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all(0);
    check_all(1);
  endtask

  task automatic chk_reset_state(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_out_valid"}, i, int'(out_valid_w[i]), 0);
      chk({tag, "_data"}, i, int'(data_w[i]), 0);
      chk({tag, "_in_ready"}, i, int'(in_ready_w[i]), 1);
      chk({tag, "_cnt0"}, i, int'(cnt0_w[i]), 0);
      chk({tag, "_cnt1"}, i, int'(cnt1_w[i]), 0);
      chk({tag, "_stall_err"}, i, int'(err_w[i]), 0);
    end
  endtask

  initial begin
    model_reset();
    #12;
    chk_reset_state("reset");
    chk("reset_sel", 0, int'(sel_w[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin basic: A,B,C,D alternate channels, one cycle latency
    ch_ready = 2'b11; in_dest = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 4'(4'hA + k);
      tick();
      chk("rr_sel", 0, int'(sel_w[0]), k % 2);
      chk("rr_data", 0, int'(data_w[0]), 'hA + k);
    end
    in_valid = 1'b0;
    tick();
    chk("rr_cnt0", 0, int'(cnt0_w[0]), 2);
    chk("rr_cnt1", 0, int'(cnt1_w[0]), 2);
    chk("dir_cnt0", 1, int'(cnt0_w[1]), 4);

    // Directed with backpressure on channel 1
    clr = 1'b1; tick(); clr = 1'b0;
    ch_ready = 2'b01; in_valid = 1'b1; in_data = 4'h5; in_dest = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_sel", 1, int'(sel_w[1]), 1);
      chk("bp_hold_data", 1, int'(data_w[1]), 5);
      chk("bp_hold_cnt1", 1, int'(cnt1_w[1]), 0);
    end
    ch_ready = 2'b11;
    tick();
    chk("bp_cnt1", 1, int'(cnt1_w[1]), 1);
    chk("bp_idle", 1, int'(out_valid_w[1]), 0);

    // FIFO full: 1 in the output register plus D buffered, then drain in order
    ch_ready = 2'b00; in_valid = 1'b1; in_dest = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      in_data = 4'(k);
      tick();
    end
    chk("full_in_ready", 0, int'(in_ready_w[0]), 0);
    in_data = 4'h6;
    tick();
    chk("full_hold_off", 1, int'(in_ready_w[1]), 0);
    chk("full_head", 1, int'(data_w[1]), 1);
    in_valid = 1'b0; ch_ready = 2'b11;
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk("drain_data", 0, int'(data_w[0]), k);
      chk("drain_data", 1, int'(data_w[1]), k);
    end
    tick();
    chk("drain_empty", 1, int'(out_valid_w[1]), 0);

    // Timeout: stall_err after exactly T stalled cycles, sticky, cleared by clr
    clr = 1'b1; tick(); clr = 1'b0;
    ch_ready = 2'b00; in_valid = 1'b1; in_data = 4'h7;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < T - 1; k++) tick();
    chk("to_before", 1, int'(err_w[1]), 0);
    tick();
    chk("to_set", 1, int'(err_w[1]), 1);
    chk("to_set", 0, int'(err_w[0]), 1);
    ch_ready = 2'b11;
    tick();
    chk("to_sticky", 1, int'(err_w[1]), 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("to_clr", 1, int'(err_w[1]), 0);

    // Counter wrap on channel 0 of the directed instance
    in_valid = 1'b1; in_dest = 1'b0;
    for (int k = 0; k < 256; k++) begin
      in_data = 4'(k);
      tick();
    end
    chk("wrap_255", 1, int'(cnt0_w[1]), 255);
    in_valid = 1'b0;
    tick();
    chk("wrap_0", 1, int'(cnt0_w[1]), 0);
    // clr in the same cycle as a transfer wins
    in_valid = 1'b1; in_data = 4'h3;
    tick(); tick();
    in_valid = 1'b0;
    chk("race_pre", 1, int'(cnt0_w[1]), 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("race_clr", 1, int'(cnt0_w[1]), 0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 4'($urandom);
      in_dest  = 1'($urandom);
      ch_ready = 2'($urandom);
      clr      = ($urandom_range(0, 31) == 0);
      tick();
    end
    clr = 1'b0;

    // Async reset mid-stream with nibbles buffered
    ch_ready = 2'b00; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 4'(k + 8);
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_state("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ch_ready = 2'b11;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_idle", 0, int'(out_valid_w[0]), 0);
      chk("post_rst_idle", 1, int'(out_valid_w[1]), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
